// File: rtl/mfsk_modulator.sv
// M-ary FSK frame modulator: emits BITS_PER_SYM-bit tone indices MSB-first with
// programmable symbol time, repetitions and guard gaps. Define MFSK_GRAY_EN for Gray-coded tone_sel.
module mfsk_modulator #(
  parameter int FRAME_BITS   = 128,
  parameter int BITS_PER_SYM = 1,
  parameter int SYM_TIME_W   = 16,
  parameter int REP_W        = 4,
  parameter int GUARD_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [FRAME_BITS-1:0]   in_bitstream,
  input  logic [SYM_TIME_W-1:0]   symbol_time,
  input  logic [REP_W-1:0]        repetition_factor,
  input  logic [GUARD_W-1:0]      guard_time,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    wave_enable,
  output logic [BITS_PER_SYM-1:0] tone_sel,
  output logic                    sym_strobe
);

  localparam int NSYM = FRAME_BITS / BITS_PER_SYM;
  localparam int SCW  = $clog2(NSYM + 1);

  typedef enum logic [1:0] {S_IDLE, S_SYMBOL, S_GUARD, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [SCW-1:0]          sym_cnt_q, sym_cnt_d;
  logic [SYM_TIME_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [SYM_TIME_W-1:0]   sym_time_q, sym_time_d;
  logic [REP_W-1:0]        rep_cnt_q, rep_cnt_d;
  logic [GUARD_W-1:0]      guard_cnt_q, guard_cnt_d;
  logic [GUARD_W-1:0]      guard_time_q, guard_time_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    wave_q, wave_d;
  logic                    strobe_q, strobe_d;
  logic [BITS_PER_SYM-1:0] tone_q, tone_d;

  function automatic logic [BITS_PER_SYM-1:0] encode_tone(input logic [BITS_PER_SYM-1:0] s);
`ifdef MFSK_GRAY_EN
    return s ^ (s >> 1);
`else
    return s;
`endif
  endfunction

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    shift_d      = shift_q;
    sym_cnt_d    = sym_cnt_q;
    cyc_cnt_d    = cyc_cnt_q;
    sym_time_d   = sym_time_q;
    rep_cnt_d    = rep_cnt_q;
    guard_cnt_d  = guard_cnt_q;
    guard_time_d = guard_time_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          frame_d      = in_bitstream;
          shift_d      = in_bitstream;
          sym_cnt_d    = SCW'(NSYM);
          cyc_cnt_d    = '0;
          sym_time_d   = (symbol_time == '0) ? SYM_TIME_W'(1) : symbol_time;
          rep_cnt_d    = (repetition_factor == '0) ? REP_W'(1) : repetition_factor;
          guard_time_d = guard_time;
          state_d      = S_SYMBOL;
        end
      end
      S_SYMBOL: begin
        if (cyc_cnt_q == sym_time_q - SYM_TIME_W'(1)) begin
          cyc_cnt_d = '0;
          if (sym_cnt_q == SCW'(1)) begin
            if (rep_cnt_q > REP_W'(1)) begin
              // Reload now; tone_sel is forced to zero while guarding anyway.
              rep_cnt_d = rep_cnt_q - REP_W'(1);
              shift_d   = frame_q;
              sym_cnt_d = SCW'(NSYM);
              if (guard_time_q != '0) begin
                state_d     = S_GUARD;
                guard_cnt_d = '0;
              end
            end else begin
              state_d = S_DONE;
            end
          end else begin
            shift_d   = shift_q << BITS_PER_SYM;
            sym_cnt_d = sym_cnt_q - SCW'(1);
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + SYM_TIME_W'(1);
        end
      end
      S_GUARD: begin
        if (guard_cnt_q == guard_time_q - GUARD_W'(1)) begin
          state_d = S_SYMBOL;
        end else begin
          guard_cnt_d = guard_cnt_q + GUARD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the next state so they appear registered with no extra latency.
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    wave_d   = (state_d == S_SYMBOL);
    strobe_d = (state_d == S_SYMBOL) && (cyc_cnt_d == '0);
    tone_d   = wave_d ? encode_tone(shift_d[FRAME_BITS-1 -: BITS_PER_SYM]) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      frame_q      <= '0;
      shift_q      <= '0;
      sym_cnt_q    <= '0;
      cyc_cnt_q    <= '0;
      sym_time_q   <= '0;
      rep_cnt_q    <= '0;
      guard_cnt_q  <= '0;
      guard_time_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wave_q       <= 1'b0;
      strobe_q     <= 1'b0;
      tone_q       <= '0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      shift_q      <= shift_d;
      sym_cnt_q    <= sym_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
      sym_time_q   <= sym_time_d;
      rep_cnt_q    <= rep_cnt_d;
      guard_cnt_q  <= guard_cnt_d;
      guard_time_q <= guard_time_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wave_q       <= wave_d;
      strobe_q     <= strobe_d;
      tone_q       <= tone_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign wave_enable = wave_q;
  assign sym_strobe  = strobe_q;
  assign tone_sel    = tone_q;

endmodule
